// File: rtl/multi_edge_sync_if.sv
// multi_edge_sync_if: per-channel async inputs, clears and synchronised event outputs
interface multi_edge_sync_if #(parameter int CH = 4);
  logic [CH-1:0] async_in;
  logic [CH-1:0] evt_clr;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;
  logic [CH-1:0] evt_pending;
  logic [CH-1:0] evt_overrun;
  modport master (output async_in, evt_clr, input level, pulse, evt_pending, evt_overrun);
  modport slave (input async_in, evt_clr, output level, pulse, evt_pending, evt_overrun);
endinterface

// File: rtl/multi_edge_sync.sv
// multi_edge_sync: per-channel synchroniser, optional debounce, edge strobe and sticky event flags
module multi_edge_sync #(
  parameter int   CH          = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYCLES  = 0,
  parameter int   EDGE_MODE   = 0,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input logic clk,
  input logic rst,
  multi_edge_sync_if.slave bus
);
  if (CH < 1 || CH > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEB_CYCLES < 0 ||
      DEB_CYCLES > 65535 || EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_param
    $error("multi_edge_sync: illegal parameter value");
  end
  localparam int CW = DEB_CYCLES > 0 ? $clog2(DEB_CYCLES) + 1 : 1;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic lvl, hist, det, det_n, pulse_q, pend, ovr, rise, fall;
    always_ff @(posedge clk or posedge rst)
      if (rst) sync <= {SYNC_STAGES{INIT_LEVEL}};
      else sync <= {sync[SYNC_STAGES-2:0], bus.async_in[i]};
    if (DEB_CYCLES == 0) begin : g_nodeb
      assign lvl = sync[SYNC_STAGES-1];
    end else begin : g_deb
      logic [CW-1:0] cnt;
      logic diff;
      assign diff = sync[SYNC_STAGES-1] ^ lvl;
      // level only flips after DEB_CYCLES consecutive cycles of disagreement
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          cnt <= '0;
          lvl <= INIT_LEVEL;
        end else if (!diff) begin
          cnt <= '0;
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
          cnt <= '0;
          lvl <= ~lvl;
        end else begin
          cnt <= cnt + 1'b1;
        end
    end
    assign rise  = lvl & ~hist;
    assign fall  = ~lvl & hist;
    assign det_n = EDGE_MODE == 0 ? rise : EDGE_MODE == 1 ? fall : rise | fall;
    // a coincident pulse wins over clear; overrun only rises when an old event is lost
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        hist    <= INIT_LEVEL;
        det     <= 1'b0;
        pulse_q <= 1'b0;
        pend    <= 1'b0;
        ovr     <= 1'b0;
      end else begin
        hist    <= lvl;
        det     <= det_n;
        pulse_q <= det;
        pend    <= pulse_q | (pend & ~bus.evt_clr[i]);
        ovr     <= pulse_q ? ovr | (pend & ~bus.evt_clr[i]) : ovr & ~bus.evt_clr[i];
      end
    assign bus.level[i]       = lvl;
    assign bus.pulse[i]       = pulse_q;
    assign bus.evt_pending[i] = pend;
    assign bus.evt_overrun[i] = ovr;
  end
endmodule
